// File: rtl/palette_pkg.sv
// Shared types and the fade arithmetic for the writable colour palette.
package palette_pkg;

  localparam int PAL_CH_W   = 4;
  localparam int PAL_FADE_W = 4;

  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } pal_state_e;

  // chan * (fade + 1) >> FADE_W, so an all-ones fade is the identity.
  function automatic logic [PAL_CH_W-1:0] fade_chan(input logic [PAL_CH_W-1:0]   chan,
                                                    input logic [PAL_FADE_W-1:0] fade);
    logic [PAL_CH_W+PAL_FADE_W:0] prod;
    prod = {{(PAL_FADE_W+1){1'b0}}, chan} * {{PAL_CH_W{1'b0}}, ({1'b0, fade} + 1'b1)};
    return prod[PAL_FADE_W +: PAL_CH_W];
  endfunction

  function automatic rgb_t fade_scale(input rgb_t c, input logic [PAL_FADE_W-1:0] fade);
    rgb_t s;
    s.r = fade_chan(c.r, fade);
    s.g = fade_chan(c.g, fade);
    s.b = fade_chan(c.b, fade);
    return s;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette storage: one write port, one registered read-first read port.
module palette_ram #(
  parameter int AW = 8,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // No reset on the array so it maps onto block RAM; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/palette_lut_rgb.sv
// Writable, pipelined colour palette with clear sweep, transparency flag and global fade.
//  state | meaning
//  CLEAR | sweeping zeros into every entry, writes blocked, busy = 1
//  IDLE  | palette usable, writes accepted
module palette_lut_rgb
  import palette_pkg::*;
#(
  parameter int IDX_W      = 8,
  parameter int TRANSP_IDX = 0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  rd_valid,
  input  logic [IDX_W-1:0]      rd_index,
  input  logic [PAL_FADE_W-1:0] fade_level,
  output logic                  rd_out_valid,
  output logic [PAL_CH_W-1:0]   red,
  output logic [PAL_CH_W-1:0]   green,
  output logic [PAL_CH_W-1:0]   blue,
  output logic                  rd_transparent,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic [3*PAL_CH_W-1:0] wr_rgb,
  input  logic                  clear_start,
  output logic                  busy
);

  localparam int DEPTH = 2**IDX_W;

  pal_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  rgb_t             ram_wdata;
  rgb_t             ram_rdata;
  rgb_t             scaled;

  logic                  s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]      s1_index_q, s1_index_d;
  logic [PAL_FADE_W-1:0] s1_fade_q, s1_fade_d;
  logic                  s1_blank_q, s1_blank_d;

  logic                out_valid_q, out_valid_d;
  rgb_t                out_rgb_q, out_rgb_d;
  logic                out_transp_q, out_transp_d;

  assign busy     = (state_q == CLEAR);
  assign wr_ready = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = wr_index;
    ram_wdata = wr_rgb;
    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        ram_we = wr_valid;
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  palette_ram #(
    .AW(IDX_W),
    .DW(3*PAL_CH_W)
  ) u_ram (
    .clk  (Clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(rd_index),
    .rdata(ram_rdata)
  );

  assign scaled = fade_scale(ram_rdata, s1_fade_q);

  // Lookups issued during the sweep may see stale RAM, so they are blanked at the output.
  always_comb begin
    s1_valid_d   = rd_valid;
    s1_index_d   = rd_index;
    s1_fade_d    = fade_level;
    s1_blank_d   = busy;
    out_valid_d  = s1_valid_q;
    out_rgb_d    = out_rgb_q;
    out_transp_d = out_transp_q;
    if (s1_valid_q) begin
      out_rgb_d    = s1_blank_q ? '0 : scaled;
      out_transp_d = (s1_index_q == IDX_W'(TRANSP_IDX));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_index_q   <= '0;
      s1_fade_q    <= '0;
      s1_blank_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_rgb_q    <= '0;
      out_transp_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_index_q   <= s1_index_d;
      s1_fade_q    <= s1_fade_d;
      s1_blank_q   <= s1_blank_d;
      out_valid_q  <= out_valid_d;
      out_rgb_q    <= out_rgb_d;
      out_transp_q <= out_transp_d;
    end
  end

  assign rd_out_valid   = out_valid_q;
  assign red            = out_rgb_q.r;
  assign green          = out_rgb_q.g;
  assign blue           = out_rgb_q.b;
  assign rd_transparent = out_transp_q;

endmodule
